// File: rtl/syscall_responder.sv
// Console-device responder for CPU syscalls: print_int, print_string, print_char and exit.
// Holds busy while a service is in progress so the pipeline stalls until it completes.
module syscall_responder #(
    parameter int unsigned MAX_STR_LEN = 256
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        syscall_valid_i,
    input  logic [31:0] syscall_funct_i,
    input  logic [31:0] syscall_param_i,
    output logic        busy_o,
    output logic [7:0]  out_data_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [7:0]  mem_rdata_i,
    output logic        halted_o,
    output logic [31:0] exit_code_o
);

    localparam logic [31:0] FnPrintInt  = 32'd1;
    localparam logic [31:0] FnPrintStr  = 32'd4;
    localparam logic [31:0] FnExit      = 32'd10;
    localparam logic [31:0] FnPrintChar = 32'd11;
    localparam logic [31:0] FnExit2     = 32'd17;

    typedef enum logic [2:0] {
        StIdle,
        StChar,
        StIntSign,
        StIntCalc,
        StIntEmit,
        StStrReq,
        StStrEmit,
        StHalt
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  out_data_q, out_data_d;
    logic [31:0] ptr_q, ptr_d;
    logic [31:0] count_q, count_d;
    logic [31:0] mag_q, mag_d;
    logic [3:0]  pow_idx_q, pow_idx_d;
    logic [3:0]  digit_q, digit_d;
    logic        started_q, started_d;
    logic        halted_q, halted_d;
    logic [31:0] exit_code_q, exit_code_d;
    logic [31:0] pow_val;

    function automatic logic [31:0] pow10(input logic [3:0] idx);
        logic [31:0] v;
        case (idx)
            4'd0:    v = 32'd1;
            4'd1:    v = 32'd10;
            4'd2:    v = 32'd100;
            4'd3:    v = 32'd1000;
            4'd4:    v = 32'd10000;
            4'd5:    v = 32'd100000;
            4'd6:    v = 32'd1000000;
            4'd7:    v = 32'd10000000;
            4'd8:    v = 32'd100000000;
            4'd9:    v = 32'd1000000000;
            default: v = 32'd1;
        endcase
        return v;
    endfunction

    assign pow_val = pow10(pow_idx_q);

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        ptr_d       = ptr_q;
        count_d     = count_q;
        mag_d       = mag_q;
        pow_idx_d   = pow_idx_q;
        digit_d     = digit_q;
        started_d   = started_q;
        halted_d    = halted_q;
        exit_code_d = exit_code_q;

        unique case (state_q)
            StIdle: begin
                if (syscall_valid_i) begin
                    case (syscall_funct_i)
                        FnPrintChar: begin
                            out_data_d = syscall_param_i[7:0];
                            state_d    = StChar;
                        end
                        FnPrintInt: begin
                            // Two's-complement magnitude; 0x80000000 maps to 2147483648.
                            mag_d     = syscall_param_i[31] ? (~syscall_param_i + 32'd1)
                                                            : syscall_param_i;
                            pow_idx_d = 4'd9;
                            digit_d   = 4'd0;
                            started_d = 1'b0;
                            if (syscall_param_i[31]) begin
                                out_data_d = 8'h2D;
                                state_d    = StIntSign;
                            end else begin
                                state_d = StIntCalc;
                            end
                        end
                        FnPrintStr: begin
                            ptr_d   = syscall_param_i;
                            count_d = 32'd0;
                            state_d = StStrReq;
                        end
                        FnExit: begin
                            halted_d    = 1'b1;
                            exit_code_d = 32'd0;
                            state_d     = StHalt;
                        end
                        FnExit2: begin
                            halted_d    = 1'b1;
                            exit_code_d = syscall_param_i;
                            state_d     = StHalt;
                        end
                        default: ;
                    endcase
                end
            end
            StChar: begin
                if (out_ready_i) state_d = StIdle;
            end
            StIntSign: begin
                if (out_ready_i) state_d = StIntCalc;
            end
            StIntCalc: begin
                if (mag_q >= pow_val) begin
                    mag_d   = mag_q - pow_val;
                    digit_d = digit_q + 4'd1;
                end else if (digit_q != 4'd0 || started_q || pow_idx_q == 4'd0) begin
                    out_data_d = 8'h30 + {4'h0, digit_q};
                    state_d    = StIntEmit;
                end else begin
                    // Leading zero: skip straight to the next power.
                    pow_idx_d = pow_idx_q - 4'd1;
                end
            end
            StIntEmit: begin
                if (out_ready_i) begin
                    started_d = 1'b1;
                    digit_d   = 4'd0;
                    if (pow_idx_q == 4'd0) begin
                        state_d = StIdle;
                    end else begin
                        pow_idx_d = pow_idx_q - 4'd1;
                        state_d   = StIntCalc;
                    end
                end
            end
            StStrReq: begin
                if (mem_ack_i) begin
                    if (mem_rdata_i == 8'h00 || count_q >= MAX_STR_LEN) begin
                        state_d = StIdle;
                    end else begin
                        out_data_d = mem_rdata_i;
                        state_d    = StStrEmit;
                    end
                end
            end
            StStrEmit: begin
                if (out_ready_i) begin
                    count_d = count_q + 32'd1;
                    // Stop at the limit without issuing another read.
                    if (count_q + 32'd1 >= MAX_STR_LEN) begin
                        state_d = StIdle;
                    end else begin
                        ptr_d   = ptr_q + 32'd1;
                        state_d = StStrReq;
                    end
                end
            end
            StHalt: ;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            out_data_q  <= 8'h00;
            ptr_q       <= 32'd0;
            count_q     <= 32'd0;
            mag_q       <= 32'd0;
            pow_idx_q   <= 4'd0;
            digit_q     <= 4'd0;
            started_q   <= 1'b0;
            halted_q    <= 1'b0;
            exit_code_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            mag_q       <= mag_d;
            pow_idx_q   <= pow_idx_d;
            digit_q     <= digit_d;
            started_q   <= started_d;
            halted_q    <= halted_d;
            exit_code_q <= exit_code_d;
        end
    end

    assign busy_o      = (state_q != StIdle);
    assign out_valid_o = (state_q == StChar) || (state_q == StIntSign) ||
                         (state_q == StIntEmit) || (state_q == StStrEmit);
    assign out_data_o  = out_data_q;
    assign mem_req_o   = (state_q == StStrReq);
    assign mem_addr_o  = ptr_q;
    assign halted_o    = halted_q;
    assign exit_code_o = exit_code_q;

endmodule
